rtc_timekeeper: RTL and testbench

Parametrised real-time clock core that derives a one-second tick from the system clock and keeps hours/minutes/seconds with wrap-around. It adds run/pause, validated time load, runtime-selectable 12/24-hour display with PM flag, day-wrap indication and an optional alarm. It sits between the board clock and display/bus logic as the single source of wall-clock time.

---
 rtl/rtc_timekeeper.sv | 162 ++++++++++++++++
 tb/tb_rtc_timekeeper.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_timekeeper.sv
// Real-time clock core: prescaled one-second tick, validated HH:MM:SS load, 12/24 h display.
// Optional alarm logic is built only when RTC_ALARM_EN is defined.
module rtc_timekeeper #(
  parameter int TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       mode_12h,
  input  logic       load,
  input  logic [4:0] load_h,
  input  logic [5:0] load_m,
  input  logic [5:0] load_s,
  input  logic       alarm_set,
  input  logic [4:0] alarm_h,
  input  logic [5:0] alarm_m,
  input  logic       alarm_on,
  input  logic       alarm_clr,
  output logic [4:0] hours,
  output logic [5:0] mins,
  output logic [5:0] secs,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       load_err,
  output logic       alarm
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  // Maps the internal 0..23 hour onto the selected display format.
  function automatic logic [4:0] disp_hour(input logic [4:0] h24, input logic fmt12);
    if (!fmt12)
      return h24;
    if (h24 == 5'd0)
      return 5'd12;
    if (h24 > 5'd12)
      return h24 - 5'd12;
    return h24;
  endfunction

  logic [DIV_W-1:0] r_div;
  logic [4:0]       r_hr;
  logic [5:0]       r_min;
  logic [5:0]       r_sec;
  logic             r_sec_tick;
  logic             r_day_wrap;
  logic             r_load_err;

  logic             w_term;
  logic             w_load_ok;
  logic             w_load_acc;
  logic             w_adv;
  logic [4:0]       w_hr_nx;
  logic [5:0]       w_min_nx;
  logic [5:0]       w_sec_nx;
  logic             w_wrap_nx;

  assign w_term     = run && (r_div == DIV_LAST);
  assign w_load_ok  = (load_h <= 5'd23) && (load_m <= 6'd59) && (load_s <= 6'd59);
  assign w_load_acc = load && w_load_ok;
  // An accepted load on the terminal-count cycle swallows that tick.
  assign w_adv      = w_term && !w_load_acc;

  always_comb begin
    w_sec_nx  = r_sec + 6'd1;
    w_min_nx  = r_min;
    w_hr_nx   = r_hr;
    w_wrap_nx = 1'b0;
    if (r_sec == 6'd59) begin
      w_sec_nx = 6'd0;
      if (r_min == 6'd59) begin
        w_min_nx = 6'd0;
        if (r_hr == 5'd23) begin
          w_hr_nx   = 5'd0;
          w_wrap_nx = 1'b1;
        end else begin
          w_hr_nx = r_hr + 5'd1;
        end
      end else begin
        w_min_nx = r_min + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div      <= '0;
      r_hr       <= '0;
      r_min      <= '0;
      r_sec      <= '0;
      r_sec_tick <= 1'b0;
      r_day_wrap <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_sec_tick <= w_adv;
      r_day_wrap <= w_adv && w_wrap_nx;
      r_load_err <= load && !w_load_ok;
      if (w_load_acc) begin
        r_div <= '0;
        r_hr  <= load_h;
        r_min <= load_m;
        r_sec <= load_s;
      end else if (run) begin
        if (w_term) begin
          r_div <= '0;
          r_hr  <= w_hr_nx;
          r_min <= w_min_nx;
          r_sec <= w_sec_nx;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
    end
  end

  assign hours    = disp_hour(r_hr, mode_12h);
  assign pm       = (r_hr >= 5'd12);
  assign mins     = r_min;
  assign secs     = r_sec;
  assign sec_tick = r_sec_tick;
  assign day_wrap = r_day_wrap;
  assign load_err = r_load_err;

`ifdef RTC_ALARM_EN
  logic [4:0] r_alm_h;
  logic [5:0] r_alm_m;
  logic       r_alarm;
  logic       w_alm_ok;
  logic       w_alm_hit;

  assign w_alm_ok  = (alarm_h <= 5'd23) && (alarm_m <= 6'd59);
  // Only a real advance can trigger; landing on the alarm time via load does not.
  assign w_alm_hit = w_adv && alarm_on && (w_sec_nx == 6'd0) &&
                     (w_min_nx == r_alm_m) && (w_hr_nx == r_alm_h);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alm_h <= '0;
      r_alm_m <= '0;
      r_alarm <= 1'b0;
    end else begin
      if (alarm_set && w_alm_ok) begin
        r_alm_h <= alarm_h;
        r_alm_m <= alarm_m;
      end
      if (w_alm_hit)
        r_alarm <= 1'b1;
      else if (alarm_clr)
        r_alarm <= 1'b0;
    end
  end

  assign alarm = r_alarm;
`else
  logic w_unused_alarm;
  assign w_unused_alarm = ^{alarm_set, alarm_h, alarm_m, alarm_on, alarm_clr};
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Self-checking bench for rtc_timekeeper (TICK_DIV=4): vector table, corner sequences,
// and randomized traffic against a seconds-of-day reference model.
module tb_rtc_timekeeper;

  localparam int TD = 4;
`ifdef RTC_ALARM_EN
  localparam bit ALM = 1'b1;
`else
  localparam bit ALM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       mode_12h = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_h = '0;
  logic [5:0] load_m = '0;
  logic [5:0] load_s = '0;
  logic       alarm_set = 1'b0;
  logic [4:0] alarm_h = '0;
  logic [5:0] alarm_m = '0;
  logic       alarm_on = 1'b0;
  logic       alarm_clr = 1'b0;
  logic [4:0] hours;
  logic [5:0] mins;
  logic [5:0] secs;
  logic       pm;
  logic       sec_tick;
  logic       day_wrap;
  logic       load_err;
  logic       alarm;

  int n_checks = 0;
  int n_fail   = 0;

  rtc_timekeeper #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .run(run), .mode_12h(mode_12h), .load(load),
    .load_h(load_h), .load_m(load_m), .load_s(load_s),
    .alarm_set(alarm_set), .alarm_h(alarm_h), .alarm_m(alarm_m),
    .alarm_on(alarm_on), .alarm_clr(alarm_clr),
    .hours(hours), .mins(mins), .secs(secs), .pm(pm),
    .sec_tick(sec_tick), .day_wrap(day_wrap), .load_err(load_err), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // Reference model: time of day as a single seconds count.
  int m_tod, m_cnt, m_ah, m_am;
  bit m_tick, m_wrap, m_err, m_alarm;

  function automatic int exp_hours(input int h24, input bit fmt12);
    if (!fmt12) return h24;
    if (h24 == 0) return 12;
    if (h24 > 12) return h24 - 12;
    return h24;
  endfunction

  task automatic model_step();
    bit ok, hit;
    int t;
    if (rst) begin
      m_tod = 0; m_cnt = 0; m_ah = 0; m_am = 0;
      m_tick = 0; m_wrap = 0; m_err = 0; m_alarm = 0;
      return;
    end
    ok = (int'(load_h) < 24) && (int'(load_m) < 60) && (int'(load_s) < 60);
    hit = 0; m_tick = 0; m_wrap = 0;
    m_err = load && !ok;
    if (load && ok) begin
      m_tod = int'(load_h) * 3600 + int'(load_m) * 60 + int'(load_s);
      m_cnt = 0;
    end else if (run) begin
      if (m_cnt == TD - 1) begin
        m_cnt = 0;
        m_tod = (m_tod + 1) % 86400;
        m_tick = 1;
        m_wrap = (m_tod == 0);
        t = m_tod / 60;
        hit = alarm_on && (m_tod % 60 == 0) && (t == m_ah * 60 + m_am);
      end else begin
        m_cnt++;
      end
    end
    if (ALM) begin
      if (alarm_set && int'(alarm_h) < 24 && int'(alarm_m) < 60) begin
        m_ah = int'(alarm_h);
        m_am = int'(alarm_m);
      end
      if (hit) m_alarm = 1;
      else if (alarm_clr) m_alarm = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    bit r, md, ld;
    int lh, lm, ls;
    int eh, em, es;
    bit epm, et, ew, ee;
  } vec_t;
  vec_t vq[$];

  function automatic void add(input bit r, input bit md, input bit ld,
                              input int lh, input int lm, input int ls,
                              input int eh, input int em, input int es,
                              input bit epm, input bit et, input bit ew, input bit ee);
    vec_t v;
    v.r = r; v.md = md; v.ld = ld; v.lh = lh; v.lm = lm; v.ls = ls;
    v.eh = eh; v.em = em; v.es = es; v.epm = epm; v.et = et; v.ew = ew; v.ee = ee;
    vq.push_back(v);
  endfunction

  task automatic load_time(input int h, input int m, input int s);
    load = 1; load_h = 5'(h); load_m = 6'(m); load_s = 6'(s);
    cyc();
    load = 0;
  endtask

  initial begin
    // Reset state
    cyc();
    chk("rst_hours", hours, 0);
    chk("rst_mins", mins, 0);
    chk("rst_secs", secs, 0);
    chk("rst_pm", pm, 0);
    chk("rst_tick", sec_tick, 0);
    chk("rst_wrap", day_wrap, 0);
    chk("rst_err", load_err, 0);
    chk("rst_alarm", alarm, 0);
    mode_12h = 1; #1;
    chk("rst_hours12", hours, 12);
    mode_12h = 0;
    rst = 0;

    // Vector table: run md ld lh lm ls | eh em es pm tick wrap err
    add(1,0,0, 0,0,0,    0,0,0,   0,0,0,0);
    add(1,0,0, 0,0,0,    0,0,0,   0,0,0,0);
    add(1,0,0, 0,0,0,    0,0,0,   0,0,0,0);
    add(1,0,0, 0,0,0,    0,0,1,   0,1,0,0);
    add(0,0,0, 0,0,0,    0,0,1,   0,0,0,0);
    add(0,0,0, 0,0,0,    0,0,1,   0,0,0,0);
    add(1,0,0, 0,0,0,    0,0,1,   0,0,0,0);
    add(1,0,0, 0,0,0,    0,0,1,   0,0,0,0);
    add(1,0,0, 0,0,0,    0,0,1,   0,0,0,0);
    add(1,0,0, 0,0,0,    0,0,2,   0,1,0,0);
    add(0,0,1, 23,59,58, 23,59,58,1,0,0,0);
    add(1,0,0, 0,0,0,    23,59,58,1,0,0,0);
    add(1,0,0, 0,0,0,    23,59,58,1,0,0,0);
    add(1,0,0, 0,0,0,    23,59,58,1,0,0,0);
    add(1,0,0, 0,0,0,    23,59,59,1,1,0,0);
    add(1,0,0, 0,0,0,    23,59,59,1,0,0,0);
    add(1,0,0, 0,0,0,    23,59,59,1,0,0,0);
    add(1,0,0, 0,0,0,    23,59,59,1,0,0,0);
    add(1,0,0, 0,0,0,    0,0,0,   0,1,1,0);
    add(1,0,0, 0,0,0,    0,0,0,   0,0,0,0);
    add(0,0,1, 25,0,0,   0,0,0,   0,0,0,1);
    add(0,0,1, 10,60,0,  0,0,0,   0,0,0,1);
    add(0,0,0, 0,0,0,    0,0,0,   0,0,0,0);
    add(0,1,1, 12,0,0,   12,0,0,  1,0,0,0);
    add(0,1,1, 13,0,0,   1,0,0,   1,0,0,0);
    add(0,1,1, 23,0,0,   11,0,0,  1,0,0,0);
    add(0,1,1, 0,0,0,    12,0,0,  0,0,0,0);
    add(0,0,0, 0,0,0,    0,0,0,   0,0,0,0);
    add(1,0,0, 0,0,0,    0,0,0,   0,0,0,0);
    add(1,0,0, 0,0,0,    0,0,0,   0,0,0,0);
    add(1,0,0, 0,0,0,    0,0,0,   0,0,0,0);
    add(1,0,1, 5,6,7,    5,6,7,   0,0,0,0);
    add(1,0,0, 0,0,0,    5,6,7,   0,0,0,0);
    add(1,0,0, 0,0,0,    5,6,7,   0,0,0,0);
    add(1,0,0, 0,0,0,    5,6,7,   0,0,0,0);
    add(1,0,0, 0,0,0,    5,6,8,   0,1,0,0);

    foreach (vq[i]) begin
      run = vq[i].r; mode_12h = vq[i].md; load = vq[i].ld;
      load_h = 5'(vq[i].lh); load_m = 6'(vq[i].lm); load_s = 6'(vq[i].ls);
      cyc();
      n_checks++;
      if (int'(hours) != vq[i].eh || int'(mins) != vq[i].em || int'(secs) != vq[i].es ||
          pm != vq[i].epm || sec_tick != vq[i].et || day_wrap != vq[i].ew ||
          load_err != vq[i].ee) begin
        n_fail++;
        $display("FAIL row%0d: got %0d:%0d:%0d pm=%0d tick=%0d wrap=%0d err=%0d expected %0d:%0d:%0d pm=%0d tick=%0d wrap=%0d err=%0d",
                 i, hours, mins, secs, pm, sec_tick, day_wrap, load_err,
                 vq[i].eh, vq[i].em, vq[i].es, vq[i].epm, vq[i].et, vq[i].ew, vq[i].ee);
      end
    end
    load = 0; run = 0; mode_12h = 0;

    // Asynchronous reset between edges, right after a tick
    load_time(10, 20, 30);
    run = 1;
    repeat (TD) cyc();
    chk("pre_rst_tick", sec_tick, 1);
    chk("pre_rst_secs", secs, 31);
    #3 rst = 1;
    #1;
    chk("arst_hours", hours, 0);
    chk("arst_mins", mins, 0);
    chk("arst_secs", secs, 0);
    chk("arst_tick", sec_tick, 0);
    mode_12h = 1; #1;
    chk("arst_hours12", hours, 12);
    mode_12h = 0; run = 0;
    cyc();
    rst = 0;

    // Alarm sequences
    alarm_set = 1; alarm_h = 5'd7; alarm_m = 6'd30; alarm_on = 1;
    cyc();
    alarm_set = 0;
    load_time(7, 29, 59);
    chk("alm_before", alarm, 0);
    run = 1;
    repeat (TD) cyc();
    chk("alm_mins", mins, 30);
    chk("alm_secs", secs, 0);
    chk("alm_hit", alarm, ALM);
    run = 0;
    repeat (3) cyc();
    chk("alm_sticky", alarm, ALM);
    alarm_clr = 1; cyc(); alarm_clr = 0;
    chk("alm_clr", alarm, 0);
    load_time(7, 29, 59);
    run = 1;
    repeat (TD - 1) cyc();
    alarm_clr = 1; cyc(); alarm_clr = 0;
    chk("alm_set_beats_clr", alarm, ALM);
    run = 0;
    alarm_clr = 1; cyc(); alarm_clr = 0;
    alarm_on = 0;
    load_time(7, 29, 59);
    run = 1;
    repeat (TD) cyc();
    chk("alm_disarmed", alarm, 0);
    run = 0; alarm_on = 1;
    load_time(7, 30, 0);
    chk("alm_load_no_trig", alarm, 0);
    repeat (2) cyc();
    chk("alm_load_no_trig2", alarm, 0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      int eh;
      run = ($urandom_range(0, 7) != 0);
      mode_12h = 1'($urandom_range(0, 1));
      load = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 2) == 0) begin
        load_h = 5'($urandom_range(0, 24));
        load_m = 6'd59;
        load_s = 6'($urandom_range(50, 59));
      end else begin
        load_h = 5'($urandom_range(0, 31));
        load_m = 6'($urandom_range(0, 63));
        load_s = 6'($urandom_range(0, 63));
      end
      alarm_set = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 0) begin
        alarm_h = 5'(m_tod / 3600);
        alarm_m = 6'(((m_tod / 60) + 1) % 60);
      end else begin
        alarm_h = 5'($urandom_range(0, 25));
        alarm_m = 6'($urandom_range(0, 62));
      end
      alarm_on = ($urandom_range(0, 3) != 0);
      alarm_clr = ($urandom_range(0, 29) == 0);
      cyc();
      eh = exp_hours(m_tod / 3600, mode_12h);
      n_checks++;
      if (int'(hours) != eh || int'(mins) != (m_tod / 60) % 60 || int'(secs) != m_tod % 60 ||
          pm != (m_tod >= 12 * 3600) || sec_tick != m_tick || day_wrap != m_wrap ||
          load_err != m_err || alarm != m_alarm) begin
        n_fail++;
        $display("FAIL rand%0d: got %0d:%0d:%0d pm=%0d tick=%0d wrap=%0d err=%0d alarm=%0d expected %0d:%0d:%0d pm=%0d tick=%0d wrap=%0d err=%0d alarm=%0d",
                 n, hours, mins, secs, pm, sec_tick, day_wrap, load_err, alarm,
                 eh, (m_tod / 60) % 60, m_tod % 60, (m_tod >= 12 * 3600),
                 m_tick, m_wrap, m_err, m_alarm);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
